// File: rtl/row_bias.sv
`default_nettype none
// ============================================================================
//  Module   : row_bias
//  Purpose  : Per-row value-order store feeding each tile's brute-force
//             search. Holds a permutation of the GRID_LEN one-hot symbol
//             values. The tile whose turn it is presents a one-hot rqindex
//             with an updaterowbias strobe; the selected entry appears on
//             rowbias one cycle later.
//
//             With ROW_BIAS_SHUFFLE_EN defined, every accepted start
//             reorders the permutation with an LFSR-driven Fisher-Yates
//             shuffle, so each solve explores values in a seed-dependent
//             order. Without it the store stays at the identity
//             permutation (ascending value order), start goes straight to
//             READY and seed is ignored.
//
//  Ports    : clock          in   1           clock
//             reset          in   1           synchronous, active-high reset
//             start          in   1           latch seed and begin shuffle
//             seed           in   LFSR_W      LFSR seed, sampled on start
//             ready          out  1           permutation stable
//             rqindex        in   GRID_LEN+1  one-hot entry select; the top
//                                             bit means "exhausted"
//             updaterowbias  in   1           lookup strobe from tile
//             rowbias        out  GRID_LEN    registered one-hot value
//
//  Config   : GRID_LEN comes from the grid_dimensions macro (default 9).
//             ROW_BIAS_SHUFFLE_EN enables the shuffle engine.
//
//  Revision : 1.0  initial release
// ============================================================================

`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module row_bias #(
    // Fixed polynomial x^16+x^14+x^13+x^11+1: LFSR_W must be 16.
    parameter int                LFSR_W        = 16,
    parameter logic [LFSR_W-1:0] ZERO_SEED_SUB = 16'hACE1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LFSR_W-1:0]    seed,
    output logic                 ready,
    input  logic [`GRID_LEN:0]   rqindex,
    input  logic                 updaterowbias,
    output logic [`GRID_LEN-1:0] rowbias
);

    localparam int c_GRID_LEN = `GRID_LEN;
    localparam int c_IDXW     = (c_GRID_LEN > 1) ? $clog2(c_GRID_LEN) : 1;

    localparam logic [c_GRID_LEN-1:0] c_ONE    = {{(c_GRID_LEN-1){1'b0}}, 1'b1};
    localparam logic [c_IDXW-1:0]     c_I_INIT = c_IDXW'(c_GRID_LEN - 1);
    localparam logic [c_IDXW-1:0]     c_I_LAST = c_IDXW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHUF  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_ready;
    logic   w_start_ok;

    // Current permutation as seen by the lookup path.
    logic [c_GRID_LEN-1:0] w_arr [c_GRID_LEN];
    logic [c_GRID_LEN-1:0] w_sel;

    assign w_start_ok = start && ((r_state == IDLE) || (r_state == READY));

`ifdef ROW_BIAS_SHUFFLE_EN
    // ------------------------------------------------------------------
    // Shuffle engine
    // ------------------------------------------------------------------
    logic [LFSR_W-1:0]     r_lfsr;
    logic [c_IDXW-1:0]     r_i;
    logic [c_GRID_LEN-1:0] r_arr [c_GRID_LEN];

    logic [LFSR_W-1:0]     w_lfsr_nxt;
    logic [LFSR_W-1:0]     w_seed_eff;
    logic [c_IDXW-1:0]     w_r;
    logic                  w_accept;
    logic                  w_unused_bits;

    // Fibonacci LFSR, shift left, taps 16/14/13/11 feed bit 0.
    assign w_lfsr_nxt = {r_lfsr[LFSR_W-2:0],
                         r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    // An all-zero seed would lock the LFSR, so substitute a known value.
    assign w_seed_eff = (seed == '0) ? ZERO_SEED_SUB : seed;

    // Draw from the pre-shift value; draws above i are rejected and the
    // next LFSR state is tried on the following cycle.
    assign w_r      = r_lfsr[c_IDXW-1:0];
    assign w_accept = (r_state == SHUF) && (w_r <= r_i);

    assign w_unused_bits = rqindex[c_GRID_LEN];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr <= ZERO_SEED_SUB;
            r_i    <= c_I_INIT;
            for (int k = 0; k < c_GRID_LEN; k++) begin
                r_arr[k] <= c_ONE << k;
            end
        end else begin
            if (w_start_ok) begin
                r_lfsr <= w_seed_eff;
                r_i    <= c_I_INIT;
            end else if (r_state == SHUF) begin
                r_lfsr <= w_lfsr_nxt;
                if (w_accept) begin
                    // Self-swap when r == i leaves the entry unchanged.
                    r_arr[r_i] <= r_arr[w_r];
                    r_arr[w_r] <= r_arr[r_i];
                    if (r_i != c_I_LAST) begin
                        r_i <= r_i - c_I_LAST;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < c_GRID_LEN; k++) begin : g_arr_view
        assign w_arr[k] = r_arr[k];
    end
`else
    // ------------------------------------------------------------------
    // Fixed identity order: entry k holds value 1<<k.
    // ------------------------------------------------------------------
    logic w_unused_bits;

    assign w_unused_bits = ^{seed, ZERO_SEED_SUB, rqindex[c_GRID_LEN]};

    for (genvar k = 0; k < c_GRID_LEN; k++) begin : g_arr_ident
        assign w_arr[k] = c_ONE << k;
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
`ifdef ROW_BIAS_SHUFFLE_EN
                    w_state_nxt = (c_GRID_LEN > 1) ? SHUF : READY;
`else
                    w_state_nxt = READY;
`endif
                end
            end
`ifdef ROW_BIAS_SHUFFLE_EN
            SHUF: begin
                // start is ignored here; the shuffle runs to completion.
                if (w_accept && (r_i == c_I_LAST)) begin
                    w_state_nxt = READY;
                end
            end
`endif
            READY: begin
                w_ready = 1'b1;
`ifdef ROW_BIAS_SHUFFLE_EN
                if (start && (c_GRID_LEN > 1)) begin
                    w_state_nxt = SHUF;
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ready = w_ready;

    // ------------------------------------------------------------------
    // Lookup path: OR of the selected entries. The exhausted bit is never
    // part of the OR, so it (and an all-zero select) yields zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < c_GRID_LEN; k++) begin
            if (rqindex[k]) begin
                w_sel = w_sel | w_arr[k];
            end
        end
    end

    // Registered on the strobe edge from the permutation as it stood before
    // that edge, so a lookup coinciding with start sees the unshuffled order.
    always_ff @(posedge clock) begin
        if (reset) begin
            rowbias <= '0;
        end else if (updaterowbias) begin
            rowbias <= w_ready ? w_sel : '0;
        end
    end

endmodule

`default_nettype wire

// File: doc/row_bias.md
Name: row_bias

Overview:
- Per-row value-order store feeding each tile's brute-force search.
- Holds a permutation of the GRID_LEN one-hot symbol values.
- Serves the tile whose turn it is: tile presents 1-hot rqindex plus updaterowbias strobe; row_bias returns the selected entry on rowbias one cycle later.
- On start, reorders the permutation with an LFSR-driven Fisher-Yates shuffle so each solve explores values in a seed-dependent order.

Parameters:
- LFSR_W, 16, width of the internal Fibonacci LFSR; fixed polynomial x^16+x^14+x^13+x^11+1, so LFSR_W must be 16.
- ZERO_SEED_SUB, 16'hACE1, value loaded instead of an all-zero seed.
- GRID_LEN is taken from the grid_dimensions header (macro), not a parameter. IDXW = $clog2(GRID_LEN), minimum 1.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  pulse; latch seed and begin shuffle.
- seed  in  16  LFSR seed, sampled when start is accepted.
- ready  out  1  permutation stable; lookups valid.
- rqindex  in  GRID_LEN+1  1-hot entry select; bit GRID_LEN means "exhausted".
- updaterowbias  in  1  lookup strobe from tile.
- rowbias  out  GRID_LEN  1-hot value at requested entry, registered.

Behaviour:
- Reset values:
  - rowbias = 0; ready = 0; state = IDLE; i = GRID_LEN-1; lfsr = ZERO_SEED_SUB.
  - arr[k] = 1<<k (identity permutation).
- States:
  - IDLE: ready=0. start -> load lfsr (seed==0 ? ZERO_SEED_SUB : seed), i = GRID_LEN-1, go SHUF. If GRID_LEN==1 go READY directly.
  - SHUF: lfsr advances every cycle (shift left, feedback = b15^b13^b12^b10 into bit0). Draw r = lfsr[IDXW-1:0] from the current (pre-shift) value.
    - If r <= i: swap arr[i] and arr[r] (self-swap when r==i). If i==1 go READY, else decrement i.
    - Otherwise reject and redraw next cycle.
  - READY: ready=1. start -> reload lfsr, i = GRID_LEN-1, go SHUF. Shuffling continues from the current arr, not from identity. ready drops the cycle after start.
- Lookup:
  - On updaterowbias, rowbias <= OR over k<GRID_LEN of (rqindex[k] ? arr[k] : 0). Valid exactly one cycle after the strobe, matching the tile's RQROWBS -> LDROWBS sequence.
  - rqindex[GRID_LEN] contributes nothing: exhausted index gives rowbias = 0.
  - rqindex all zero gives 0. Non-1-hot rqindex gives the OR of the selected entries; no error.
  - Without updaterowbias, rowbias holds its value.
  - updaterowbias while ready=0 gives rowbias <= 0.
- start while in SHUF: ignored; no seed reload.
- Simultaneous start and updaterowbias in READY: the lookup uses arr before any swap, and the shuffle begins the same edge.
- Reset mid-shuffle: all state returns to reset values, including the identity arr.
- Invariant, checkable every cycle: arr is a permutation; each entry is 1-hot, entries are pairwise disjoint, and their OR is all-ones.
- Latency: minimum GRID_LEN-1 cycles from start to ready. The lookup path has no rejection-dependent latency.

Optional Feature:
- Macro: ROW_BIAS_SHUFFLE_EN.
- Defined: behaviour as above.
- Undefined:
  - No LFSR and no SHUF state; seed is ignored.
  - start moves IDLE -> READY in one cycle; start in READY is a no-op.
  - arr stays identity, so rowbias = rqindex[GRID_LEN-1:0] registered. This gives a deterministic ascending value order for debug.

Test Plan:
- Lookup before ready: reset, then updaterowbias with rqindex=1 -> rowbias==0 next cycle; ready==0.
- Shuffle completes: GRID_LEN=9, start with seed=16'h0001 -> ready rises within 200 cycles; read all 9 indices -> each 1-hot, OR==9'h1FF, no duplicates.
- Zero seed: seed=0 vs seed=16'hACE1 -> identical 9-entry read-out sequences.
- Exhausted index: after ready, rqindex=10'h200 strobed -> rowbias==0; rqindex=0 -> 0.
- Tile timing: strobe updaterowbias one cycle with rqindex=10'h004, deassert -> rowbias==arr[2] next cycle and held 5 more cycles; reset mid-SHUF -> ready=0, rowbias=0, later lookups (after a fresh start) still a valid permutation.
- Macro undefined: start -> ready next cycle; rqindex=10'h010 -> rowbias==9'h010.
